td4_run_ctrl: RTL

//   Run/halt/single-step sequencer and program loader for the TD4 core. Gates the

---
 rtl/td4_run_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/td4_run_ctrl.sv
// Run/halt/single-step sequencer and program loader for the TD4 core.
// Gates the core with one-cycle enables and streams a program image into its RAM.
module td4_run_ctrl #(
   parameter int unsigned CLK_DIV = 24'd12_000_000,
   parameter int unsigned DIV_W   = 24,
   parameter int unsigned ADDR_W  = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_cmd_run,
   input  logic              i_cmd_halt,
   input  logic              i_cmd_step,
   input  logic              i_cmd_load,
   input  logic              i_ld_valid,
   input  logic [7:0]        i_ld_data,
   output logic              o_ld_ready,
   output logic              o_prog_we,
   output logic [ADDR_W-1:0] o_prog_addr,
   output logic [7:0]        o_prog_wdata,
   output logic              o_core_en,
   output logic              o_core_rst,
   output logic [1:0]        o_state,
   output logic [15:0]       o_step_cnt
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_LOAD = 2'b11
   } state_t;

   localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_t              r_state;
   logic [DIV_W-1:0]    r_div;
   logic [ADDR_W-1:0]   r_ld_addr;
   logic [ADDR_W-1:0]   r_prog_addr;
   logic [7:0]          r_prog_wdata;
   logic                r_prog_we;
   logic                r_core_rst;
   logic [15:0]         r_step_cnt;

   state_t              w_nxt;
   logic                w_core_en;
   logic                w_hs;
   logic                w_ld_done;

   always_comb begin
      w_nxt     = r_state;
      w_core_en = 1'b0;
      w_hs      = 1'b0;
      w_ld_done = 1'b0;
      case (r_state)
         S_HALT: begin
            if (i_cmd_load)      w_nxt = S_LOAD;
            else if (i_cmd_halt) w_nxt = S_HALT;
            else if (i_cmd_step) w_nxt = S_STEP;
            else if (i_cmd_run)  w_nxt = S_RUN;
         end
         S_STEP: begin
            // A load request pre-empts the pending step entirely.
            w_core_en = !i_cmd_load;
            w_nxt     = i_cmd_load ? S_LOAD : S_HALT;
         end
         S_RUN: begin
            if (i_cmd_load)      w_nxt = S_LOAD;
            else if (i_cmd_halt) w_nxt = S_HALT;
            else                 w_core_en = (r_div == DIV_MAX);
         end
         S_LOAD: begin
            // An abort in the same cycle drops the offered byte.
            w_hs = i_ld_valid && !i_cmd_halt;
            if (i_cmd_halt) begin
               w_nxt = S_HALT;
            end else if (w_hs && (r_ld_addr == ADDR_LAST)) begin
               w_nxt     = S_HALT;
               w_ld_done = 1'b1;
            end
         end
         default: w_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_HALT;
         r_div        <= '0;
         r_ld_addr    <= '0;
         r_prog_addr  <= '0;
         r_prog_wdata <= '0;
         r_prog_we    <= 1'b0;
         r_core_rst   <= 1'b1;
         r_step_cnt   <= '0;
      end else begin
         r_state    <= w_nxt;
         // Core reset covers the whole load plus the cycle after leaving it.
         r_core_rst <= (r_state == S_LOAD) || (w_nxt == S_LOAD);
         r_div      <= (r_state == S_RUN && w_nxt == S_RUN && r_div != DIV_MAX)
                       ? r_div + 1'b1 : '0;
         r_prog_we  <= w_hs;
         if (w_hs) begin
            r_prog_addr  <= r_ld_addr;
            r_prog_wdata <= i_ld_data;
            r_ld_addr    <= r_ld_addr + 1'b1;
         end
         if (r_state == S_LOAD && w_nxt == S_HALT) r_ld_addr <= '0;
         if (w_ld_done)      r_step_cnt <= '0;
         else if (w_core_en) r_step_cnt <= r_step_cnt + 1'b1;
      end
   end

   assign o_ld_ready   = (r_state == S_LOAD);
   assign o_prog_we    = r_prog_we;
   assign o_prog_addr  = r_prog_addr;
   assign o_prog_wdata = r_prog_wdata;
   assign o_core_en    = w_core_en;
   assign o_core_rst   = r_core_rst;
   assign o_state      = r_state;
   assign o_step_cnt   = r_step_cnt;

endmodule
